// File: rtl/com_bus_rr_arbiter.sv
// Coherent-bus arbiter: snoop > memory snoop > processor, round-robin within each class.
// Define ARB_HOLD_TIMEOUT_EN to enable forced release after MAX_HOLD grant cycles.
module com_bus_rr_arbiter #(
   parameter int MAX_HOLD = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] Com_Bus_Req_proc,
   input  logic [3:0] Com_Bus_Req_snoop,
   input  logic       Mem_snoop_req,
   output logic [7:0] Com_Bus_Gnt_proc,
   output logic [3:0] Com_Bus_Gnt_snoop,
   output logic       Mem_snoop_gnt,
   output logic [3:0] Gnt_id,
   output logic       Bus_busy,
   output logic       Hold_timeout
);
   typedef enum logic [1:0] {IDLE, GNT_SNOOP, GNT_MEM, GNT_PROC} state_t;
   localparam logic [3:0] ID_NONE = 4'd15;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be in 2..255");
   end

   state_t      state, state_nx;
   logic [2:0]  proc_ptr, proc_ptr_nx, proc_win;
   logic [1:0]  snp_ptr, snp_ptr_nx, snp_win;
   logic [7:0]  hold_cnt, hold_cnt_nx;
   logic [7:0]  gnt_proc_nx;
   logic [3:0]  gnt_snoop_nx;
   logic        gnt_mem_nx;
   logic [3:0]  gnt_id_nx;
   logic [12:0] req_all, req_elig;
   logic        own_req, rel;

   // Flat requester vector indexed by owner code (0-7 proc, 8-11 snoop, 12 mem)
   assign req_all = {Mem_snoop_req, Com_Bus_Req_snoop, Com_Bus_Req_proc};
   assign own_req = |{Com_Bus_Gnt_proc & Com_Bus_Req_proc,
                      Com_Bus_Gnt_snoop & Com_Bus_Req_snoop,
                      Mem_snoop_gnt & Mem_snoop_req};

   function automatic logic [2:0] rr_pick8(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] win, idx;
      win = p;
      for (int i = 7; i >= 0; i--) begin
         idx = p + 3'(i);
         if (r[idx]) win = idx;
      end
      return win;
   endfunction

   function automatic logic [1:0] rr_pick4(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] win, idx;
      win = p;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) win = idx;
      end
      return win;
   endfunction

`ifdef ARB_HOLD_TIMEOUT_EN
   logic       timeout_nx, blk_vld;
   logic [3:0] blk_id;

   assign req_elig = blk_vld ? (req_all & ~(13'd1 << blk_id)) : req_all;

   // Timed-out owner stays masked until its request is seen low once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Hold_timeout <= 1'b0;
         blk_vld      <= 1'b0;
         blk_id       <= 4'd0;
      end else begin
         Hold_timeout <= timeout_nx;
         if (timeout_nx) begin
            blk_vld <= 1'b1;
            blk_id  <= Gnt_id;
         end else if (blk_vld && !req_all[blk_id]) begin
            blk_vld <= 1'b0;
         end
      end
   end
`else
   assign req_elig     = req_all;
   assign Hold_timeout = 1'b0;
`endif

   always_comb begin
      state_nx     = state;
      proc_ptr_nx  = proc_ptr;
      snp_ptr_nx   = snp_ptr;
      hold_cnt_nx  = hold_cnt;
      gnt_proc_nx  = Com_Bus_Gnt_proc;
      gnt_snoop_nx = Com_Bus_Gnt_snoop;
      gnt_mem_nx   = Mem_snoop_gnt;
      gnt_id_nx    = Gnt_id;
      rel          = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      timeout_nx   = 1'b0;
`endif
      proc_win     = rr_pick8(req_elig[7:0], proc_ptr);
      snp_win      = rr_pick4(req_elig[11:8], snp_ptr);
      case (state)
         IDLE: begin
            gnt_proc_nx  = '0;
            gnt_snoop_nx = '0;
            gnt_mem_nx   = 1'b0;
            gnt_id_nx    = ID_NONE;
            if (|req_elig[11:8]) begin
               state_nx              = GNT_SNOOP;
               gnt_snoop_nx[snp_win] = 1'b1;
               gnt_id_nx             = {2'b10, snp_win};
               snp_ptr_nx            = snp_win + 2'd1;
               hold_cnt_nx           = '0;
            end else if (req_elig[12]) begin
               state_nx    = GNT_MEM;
               gnt_mem_nx  = 1'b1;
               gnt_id_nx   = 4'd12;
               hold_cnt_nx = '0;
            end else if (|req_elig[7:0]) begin
               state_nx              = GNT_PROC;
               gnt_proc_nx[proc_win] = 1'b1;
               gnt_id_nx             = {1'b0, proc_win};
               proc_ptr_nx           = proc_win + 3'd1;
               hold_cnt_nx           = '0;
            end
         end
         default: begin
            if (hold_cnt != 8'hFF) hold_cnt_nx = hold_cnt + 8'd1;
            rel = !own_req;
`ifdef ARB_HOLD_TIMEOUT_EN
            if (own_req && hold_cnt == 8'(MAX_HOLD - 1)) begin
               rel        = 1'b1;
               timeout_nx = 1'b1;
            end
`endif
            // Releasing always passes through IDLE, giving the turnaround cycle
            if (rel) begin
               state_nx     = IDLE;
               gnt_proc_nx  = '0;
               gnt_snoop_nx = '0;
               gnt_mem_nx   = 1'b0;
               gnt_id_nx    = ID_NONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         proc_ptr          <= '0;
         snp_ptr           <= '0;
         hold_cnt          <= '0;
         Com_Bus_Gnt_proc  <= '0;
         Com_Bus_Gnt_snoop <= '0;
         Mem_snoop_gnt     <= 1'b0;
         Gnt_id            <= ID_NONE;
         Bus_busy          <= 1'b0;
      end else begin
         state             <= state_nx;
         proc_ptr          <= proc_ptr_nx;
         snp_ptr           <= snp_ptr_nx;
         hold_cnt          <= hold_cnt_nx;
         Com_Bus_Gnt_proc  <= gnt_proc_nx;
         Com_Bus_Gnt_snoop <= gnt_snoop_nx;
         Mem_snoop_gnt     <= gnt_mem_nx;
         Gnt_id            <= gnt_id_nx;
         Bus_busy          <= (gnt_id_nx != ID_NONE);
      end
   end

endmodule

// File: tb/tb_com_bus_rr_arbiter.sv
// Scoreboard bench for com_bus_rr_arbiter: stimulus queues expected output changes
// with their cycle; a negedge monitor pops one entry per observed output change.
module tb_com_bus_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_proc = '0;
   logic [3:0] req_snoop = '0;
   logic       mem_req = 1'b0;
   logic [7:0] gnt_proc;
   logic [3:0] gnt_snoop;
   logic       mem_gnt;
   logic [3:0] gnt_id;
   logic       bus_busy;
   logic       hold_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [18:0] v;
   } exp_t;
   exp_t sb[$];

   com_bus_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Com_Bus_Req_proc (req_proc),
      .Com_Bus_Req_snoop(req_snoop),
      .Mem_snoop_req    (mem_req),
      .Com_Bus_Gnt_proc (gnt_proc),
      .Com_Bus_Gnt_snoop(gnt_snoop),
      .Mem_snoop_gnt    (mem_gnt),
      .Gnt_id           (gnt_id),
      .Bus_busy         (bus_busy),
      .Hold_timeout     (hold_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected output vector for owner code id (15 = none)
   function automatic logic [18:0] ev(input int id, input logic to);
      logic [7:0] p;
      logic [3:0] s;
      logic       m;
      p = '0;
      s = '0;
      m = 1'b0;
      if (id < 8) p[id] = 1'b1;
      else if (id < 12) s[id-8] = 1'b1;
      else if (id == 12) m = 1'b1;
      return {p, s, m, 4'(id), (id != 15), to};
   endfunction

   function automatic logic [18:0] outv();
      return {gnt_proc, gnt_snoop, mem_gnt, gnt_id, bus_busy, hold_timeout};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_at(input int c, input int id, input logic to = 1'b0);
      exp_t e;
      e.cyc = c;
      e.v   = ev(id, to);
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Monitor: every change of the output vector must match the next expected entry
   logic [18:0] prev = {8'h0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
   always @(negedge clk) begin
      logic [18:0] snap;
      exp_t        e;
      snap = outv();
      if (snap !== prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: got 0x%0h after 0x%0h (cycle %0d)", snap, prev, cyc);
         end else begin
            e = sb.pop_front();
            chk("change_cycle", cyc, e.cyc);
            chk("outputs", snap, e.v);
         end
         prev = snap;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 chk("reset_state", outv(), ev(15, 1'b0));
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Single processor request, latency 1, release next cycle
      t0 = cyc;
      req_proc = 8'h01;
      exp_at(t0 + 1, 0);
      exp_at(t0 + 2, 15);
      tick(1);
      req_proc = 8'h00;
      tick(2);

      // All processors requesting, each drops for one cycle after 2 grant cycles
      reset_pulse();
      t0 = cyc;
      req_proc = 8'hFF;
      for (int k = 0; k <= 8; k++) begin
         exp_at(t0 + 1 + 3*k, k % 8);
         exp_at(t0 + 3 + 3*k, 15);
      end
      tick(2);
      for (int k = 0; k <= 8; k++) begin
         if (k == 8) req_proc = 8'h00;
         else req_proc[k] = 1'b0;
         tick(1);
         if (k < 8) req_proc[k] = 1'b1;
         tick(2);
      end
      tick(1);

      // Class priority: snoop, then memory, then processor
      t0 = cyc;
      req_proc  = 8'h04;
      req_snoop = 4'h2;
      mem_req   = 1'b1;
      exp_at(t0 + 1, 9);
      exp_at(t0 + 2, 15);
      exp_at(t0 + 3, 12);
      exp_at(t0 + 4, 15);
      exp_at(t0 + 5, 2);
      exp_at(t0 + 6, 15);
      tick(1);
      req_snoop = 4'h0;
      tick(2);
      mem_req = 1'b0;
      tick(2);
      req_proc = 8'h00;
      tick(2);

      // No preemption: snoop raised while proc 3 holds the bus
      t0 = cyc;
      req_proc = 8'h08;
      exp_at(t0 + 1, 3);
      exp_at(t0 + 5, 15);
      exp_at(t0 + 6, 8);
      exp_at(t0 + 7, 15);
      tick(1);
      req_snoop = 4'h1;
      tick(3);
      req_proc = 8'h00;
      tick(2);
      req_snoop = 4'h0;
      tick(2);

      // Asynchronous reset during a snoop grant
      t0 = cyc;
      req_snoop = 4'h8;
      exp_at(t0 + 1, 11);
      exp_at(t0 + 2, 15);
      tick(2);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", outv(), ev(15, 1'b0));
      req_snoop = 4'h0;
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // Pointers restart from 0 after reset
      t0 = cyc;
      req_snoop = 4'hF;
      req_proc  = 8'hFF;
      exp_at(t0 + 1, 8);
      exp_at(t0 + 2, 15);
      exp_at(t0 + 3, 0);
      exp_at(t0 + 4, 15);
      tick(1);
      req_snoop = 4'h0;
      tick(2);
      req_proc = 8'h00;
      tick(2);

      // Hold limit behaviour with MAX_HOLD=4
      t0 = cyc;
      req_proc = 8'h20;
      exp_at(t0 + 1, 5);
`ifdef ARB_HOLD_TIMEOUT_EN
      exp_at(t0 + 5, 15, 1'b1);
      exp_at(t0 + 6, 15, 1'b0);
      exp_at(t0 + 12, 5);
      exp_at(t0 + 13, 15);
      tick(10);
      req_proc = 8'h00;
      tick(1);
      req_proc = 8'h20;
      tick(1);
      req_proc = 8'h00;
`else
      exp_at(t0 + 301, 15);
      tick(300);
      req_proc = 8'h00;
`endif
      tick(3);

      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/com_bus_rr_arbiter.md
COM_BUS_RR_ARBITER -- requirements
Module: com_bus_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64, meaning maximum grant cycles before forced release (range 2..255).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: Com_Bus_Req_proc  input  8  processor-side bus requests, bit i = cache i.
REQ-005 SHALL have ports: Com_Bus_Req_snoop  input  4  snoop-response bus requests.
REQ-006 SHALL have ports: Mem_snoop_req  input  1  memory snoop request.
REQ-007 SHALL have ports: Com_Bus_Gnt_proc  output  8  one-hot processor grants.
REQ-008 SHALL have ports: Com_Bus_Gnt_snoop  output  4  one-hot snoop grants.
REQ-009 SHALL have ports: Mem_snoop_gnt  output  1  memory snoop grant.
REQ-010 SHALL have ports: Gnt_id  output  4  owner code: 0-7 proc, 8-11 snoop, 12 mem, 15 none.
REQ-011 SHALL have ports: Bus_busy  output  1  OR of all grants.
REQ-012 SHALL have ports: Hold_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL implement FSM states IDLE, GNT_SNOOP, GNT_MEM, GNT_PROC; all outputs registered.
REQ-014 SHALL assert at most one of the 13 grant bits in any cycle.
REQ-015 SHALL, in IDLE, arbitrate with priority: any snoop request > Mem_snoop_req > any processor request.
REQ-016 SHALL select among snoop requests round-robin from 2-bit pointer snp_ptr; among processor requests round-robin from 3-bit pointer proc_ptr; search wraps index 7->0 / 3->0.
REQ-017 SHALL assert the selected grant on the cycle after the request is sampled in IDLE (latency 1) and set snp_ptr/proc_ptr to winner index+1 modulo width at that edge.
REQ-018 SHALL hold the grant while the owner's request stays high; owner request low at edge N -> grant low after edge N, state IDLE.
REQ-019 SHALL spend exactly one cycle in IDLE between consecutive grants (bus turnaround), even with requests pending.
REQ-020 SHALL ignore new higher-priority requests while a grant is held (no preemption).
REQ-021 SHALL keep an 8-bit hold counter, cleared on grant, incrementing each cycle in a GNT state, saturating at 255.
REQ-022 SHALL set Gnt_id to 15 and Bus_busy to 0 in IDLE; otherwise Gnt_id encodes the owner, same cycle as the grant.
REQ-023 SHALL, with no requests in IDLE, stay in IDLE with all grants low.

Reset
REQ-024 SHALL on rst_n low, asynchronously: state IDLE, all grants 0, Gnt_id 15, Bus_busy 0, Hold_timeout 0, snp_ptr 0, proc_ptr 0, counter 0.
REQ-025 SHALL, on reset asserted mid-grant, drop the grant immediately and restart arbitration from pointers 0 on the first rising edge after rst_n rises.

Configuration
REQ-026 SHALL, with ARB_HOLD_TIMEOUT_EN defined, force the grant low when the counter reaches MAX_HOLD-1 with request still high, pulse Hold_timeout one cycle, enter IDLE, and block the timed-out requester from winning until its request has been low at least one cycle.
REQ-027 SHALL, with ARB_HOLD_TIMEOUT_EN undefined, never revoke a grant, tie Hold_timeout to 0, and omit the blocking logic.

Verification
REQ-028 SHALL verify: reset, then proc req 0x01 at cycle 0 -> Com_Bus_Gnt_proc=0x01, Gnt_id=0 at cycle 1; req drop -> grant 0 next cycle, Gnt_id=15.
REQ-029 SHALL verify: proc reqs 0xFF held, each owner releases after 2 cycles -> grant order 0,1,...,7,0 with one IDLE cycle between grants.
REQ-030 SHALL verify: proc req 0x04 and snoop req 0x2 and Mem_snoop_req same cycle -> Com_Bus_Gnt_snoop=0x2 first, then Mem_snoop_gnt, then proc 2.
REQ-031 SHALL verify: proc 3 granted, snoop req 0x1 asserted mid-grant -> proc 3 keeps grant until its request drops; snoop 0 granted after one IDLE cycle.
REQ-032 SHALL verify (macro defined, MAX_HOLD=4): proc 5 holds req -> grant low after 4 grant cycles, Hold_timeout=1 one cycle, proc 5 not regranted while req stays high; macro undefined -> grant held indefinitely.
REQ-033 SHALL verify: rst_n low during snoop grant -> all grants 0 and Gnt_id=15 without waiting for a clock edge.
